// File: rtl/pcie_lat_pkg.sv
// Shared constants and pipeline-stage type for the PCIe echo-latency statistics block.
package pcie_lat_pkg;
  localparam int LAT_CNT_W     = 38;
  localparam int LAT_ADDR_W    = 13;
  localparam int LAT_SUM_W     = 56;
  localparam int LAT_SAMPLES_W = 32;
  localparam int PIPE_STAGES   = 3;
  localparam int HIST_BINS     = 8;
  localparam int HIST_CNT_W    = 32;
  localparam int HIST_IDX_W    = $clog2(HIST_BINS);

  // Stage fields are sized from the package defaults above.
  typedef struct packed {
    logic                  valid;
    logic [LAT_ADDR_W-1:0] seq;
    logic [LAT_CNT_W-1:0]  rx_stamp;
  } pipe_stage_t;
endpackage

// File: rtl/pcie_latency_stats_if.sv
// TX stamp / RX ack / latency-sample bus between the TX/RX engines and the statistics block.
interface pcie_latency_stats_if
  import pcie_lat_pkg::*;
#(
  parameter int CNT_W  = LAT_CNT_W,
  parameter int ADDR_W = LAT_ADDR_W
);
  logic              tx_stamp_valid;
  logic [ADDR_W-1:0] tx_seq;
  logic              rx_ack_valid;
  logic [ADDR_W-1:0] rx_seq;
  logic              lat_valid;
  logic [ADDR_W-1:0] lat_seq;
  logic [CNT_W-1:0]  lat_value;

  modport master (
    output tx_stamp_valid, tx_seq, rx_ack_valid, rx_seq,
    input  lat_valid, lat_seq, lat_value
  );
  modport slave (
    input  tx_stamp_valid, tx_seq, rx_ack_valid, rx_seq,
    output lat_valid, lat_seq, lat_value
  );
endinterface

// File: rtl/pcie_latency_stats_ram.sv
// Simple dual-port timestamp RAM: write-first on same-address collision, two-register read path.
module lat_stamp_ram #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 38
)(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_q;

  // rd_q is the array read register, rdata the output register.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q  <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    rdata <= rd_q;
  end
endmodule

// File: rtl/pcie_latency_stats.sv
// Echo-latency measurement: stamps TX, computes RX round-trip delta, keeps min/max/sum/count.
// Optional histogram enabled with `define PCIE_LAT_HIST_EN.
module pcie_latency_stats
  import pcie_lat_pkg::*;
#(
  parameter int CNT_W         = LAT_CNT_W,
  parameter int ADDR_W        = LAT_ADDR_W,
  parameter int SUM_W         = LAT_SUM_W,
  parameter int CNT_SAMPLES_W = LAT_SAMPLES_W
`ifdef PCIE_LAT_HIST_EN
  , parameter int HIST_SHIFT  = 4
`endif
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stats_clear,
  input  logic [CNT_W-1:0]          latency_counter,
  pcie_latency_stats_if.slave       bus,
  output logic [CNT_SAMPLES_W-1:0]  stat_count,
  output logic [CNT_W-1:0]          stat_min,
  output logic [CNT_W-1:0]          stat_max,
  output logic [SUM_W-1:0]          stat_sum,
  output logic                      stat_overflow
`ifdef PCIE_LAT_HIST_EN
  , output logic [HIST_BINS*HIST_CNT_W-1:0] hist_bins
`endif
);
  localparam int STAGES = PIPE_STAGES;

  pipe_stage_t        s0, st1_q, st2_q;
  logic               lat_valid_q;
  logic [ADDR_W-1:0]  lat_seq_q;
  logic [CNT_W-1:0]   lat_value_q;
  logic [CNT_W-1:0]   ram_rdata;
  logic [STAGES:0]    vld_pipe;

  assign s0 = '{valid: bus.rx_ack_valid, seq: bus.rx_seq, rx_stamp: latency_counter};
  assign vld_pipe = {lat_valid_q, st2_q.valid, st1_q.valid, s0.valid};

  lat_stamp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (CNT_W)
  ) u_ram (
    .clk   (clk),
    .we    (bus.tx_stamp_valid),
    .waddr (bus.tx_seq),
    .wdata (latency_counter),
    .raddr (bus.rx_seq),
    .rdata (ram_rdata)
  );

  // Stage data only moves with its valid bit; ram_rdata lines up with st2_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st1_q       <= '0;
      st2_q       <= '0;
      lat_valid_q <= 1'b0;
      lat_seq_q   <= '0;
      lat_value_q <= '0;
    end else begin
      st1_q.valid <= vld_pipe[0];
      if (vld_pipe[0]) begin
        st1_q.seq      <= s0.seq;
        st1_q.rx_stamp <= s0.rx_stamp;
      end
      st2_q.valid <= vld_pipe[1];
      if (vld_pipe[1]) begin
        st2_q.seq      <= st1_q.seq;
        st2_q.rx_stamp <= st1_q.rx_stamp;
      end
      lat_valid_q <= vld_pipe[2];
      if (vld_pipe[2]) begin
        lat_seq_q   <= st2_q.seq;
        lat_value_q <= st2_q.rx_stamp - ram_rdata;
      end
    end
  end

  assign bus.lat_valid = vld_pipe[STAGES];
  assign bus.lat_seq   = lat_seq_q;
  assign bus.lat_value = lat_value_q;

  logic [SUM_W:0]         sum_ext;
  logic [CNT_SAMPLES_W:0] cnt_ext;

  assign sum_ext = {1'b0, stat_sum} + {{(SUM_W+1-CNT_W){1'b0}}, lat_value_q};
  assign cnt_ext = {1'b0, stat_count} + {{CNT_SAMPLES_W{1'b0}}, 1'b1};

  // Clear has priority over a coincident sample update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_count    <= '0;
      stat_min      <= '1;
      stat_max      <= '0;
      stat_sum      <= '0;
      stat_overflow <= 1'b0;
    end else if (stats_clear) begin
      stat_count    <= '0;
      stat_min      <= '1;
      stat_max      <= '0;
      stat_sum      <= '0;
      stat_overflow <= 1'b0;
    end else if (lat_valid_q) begin
      stat_count <= cnt_ext[CNT_SAMPLES_W] ? '1 : cnt_ext[CNT_SAMPLES_W-1:0];
      stat_sum   <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      if (lat_value_q < stat_min) stat_min <= lat_value_q;
      if (lat_value_q > stat_max) stat_max <= lat_value_q;
      if (cnt_ext[CNT_SAMPLES_W] || sum_ext[SUM_W]) stat_overflow <= 1'b1;
    end
  end

`ifdef PCIE_LAT_HIST_EN
  logic [HIST_BINS-1:0][HIST_CNT_W-1:0] hist_q;
  logic [CNT_W-1:0]                     hist_shifted;
  logic [HIST_IDX_W-1:0]                hist_idx;

  // Top bin absorbs everything beyond the histogram range.
  assign hist_shifted = lat_value_q >> HIST_SHIFT;
  assign hist_idx = (hist_shifted > CNT_W'(HIST_BINS-1)) ? HIST_IDX_W'(HIST_BINS-1)
                                                          : hist_shifted[HIST_IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
    end else if (stats_clear) begin
      hist_q <= '0;
    end else if (lat_valid_q && (hist_q[hist_idx] != '1)) begin
      hist_q[hist_idx] <= hist_q[hist_idx] + HIST_CNT_W'(1);
    end
  end

  assign hist_bins = hist_q;
`endif
endmodule

// File: tb/tb_pcie_latency_stats.sv
// Scoreboard bench for pcie_latency_stats; histogram test included when PCIE_LAT_HIST_EN is defined.
module tb_pcie_latency_stats;
  import pcie_lat_pkg::*;

  localparam int CNT_W  = LAT_CNT_W;
  localparam int ADDR_W = LAT_ADDR_W;
  localparam int SUM_W  = LAT_SUM_W;
  localparam int SMP_W  = LAT_SAMPLES_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stats_clear = 1'b0;
  logic [CNT_W-1:0] latency_counter = '0;
  logic [SMP_W-1:0] stat_count;
  logic [CNT_W-1:0] stat_min, stat_max;
  logic [SUM_W-1:0] stat_sum;
  logic             stat_overflow;
`ifdef PCIE_LAT_HIST_EN
  logic [HIST_BINS*HIST_CNT_W-1:0] hist_bins;
`endif

  pcie_latency_stats_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

  pcie_latency_stats #(
    .CNT_W(CNT_W), .ADDR_W(ADDR_W), .SUM_W(SUM_W), .CNT_SAMPLES_W(SMP_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stats_clear     (stats_clear),
    .latency_counter (latency_counter),
    .bus             (bus),
    .stat_count      (stat_count),
    .stat_min        (stat_min),
    .stat_max        (stat_max),
    .stat_sum        (stat_sum),
    .stat_overflow   (stat_overflow)
`ifdef PCIE_LAT_HIST_EN
    , .hist_bins     (hist_bins)
`endif
  );

  always #2 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] seq;
    logic [CNT_W-1:0]  val;
    int                cyc;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  logic [CNT_W-1:0] stamp_mdl [int];
  int               checks = 0;
  int               errors = 0;
  int               pulses = 0;
  logic [CNT_W-1:0] ones_c;

  always @(negedge clk) begin
    if (bus.lat_valid === 1'b1) begin
      pulses++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL lat_unexpected: got seq=%0d value=%0d at cycle %0d, required no sample",
                 bus.lat_seq, bus.lat_value, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (bus.lat_seq !== mon_e.seq || bus.lat_value !== mon_e.val || cyc !== mon_e.cyc) begin
          errors++;
          $display("FAIL lat_sample: got seq=%0d value=%0d cycle=%0d, required seq=%0d value=%0d cycle=%0d",
                   bus.lat_seq, bus.lat_value, cyc, mon_e.seq, mon_e.val, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic tv, input logic [ADDR_W-1:0] ts,
                       input logic rv, input logic [ADDR_W-1:0] rs,
                       input logic [CNT_W-1:0] cnt);
    exp_t e;
    bus.tx_stamp_valid = tv;
    bus.tx_seq         = ts;
    bus.rx_ack_valid   = rv;
    bus.rx_seq         = rs;
    latency_counter    = cnt;
    if (rv) begin
      e.seq = rs;
      e.val = cnt - ((tv && ts == rs) ? cnt : stamp_mdl[int'(rs)]);
      e.cyc = cyc + 3;
      sb.push_back(e);
    end
    if (tv) stamp_mdl[int'(ts)] = cnt;
    step(1);
    bus.tx_stamp_valid = 1'b0;
    bus.rx_ack_valid   = 1'b0;
  endtask

  task automatic pulse_clear();
    stats_clear = 1'b1;
    step(1);
    stats_clear = 1'b0;
  endtask

  task automatic test_reset();
    step(2);
    checks += 8;
    if (bus.lat_valid !== 1'b0) begin errors++; $display("FAIL rst_lat_valid: got %0d, required 0", bus.lat_valid); end
    if (bus.lat_seq !== '0) begin errors++; $display("FAIL rst_lat_seq: got %0d, required 0", bus.lat_seq); end
    if (bus.lat_value !== '0) begin errors++; $display("FAIL rst_lat_value: got %0d, required 0", bus.lat_value); end
    if (stat_count !== '0) begin errors++; $display("FAIL rst_count: got %0d, required 0", stat_count); end
    if (stat_min !== ones_c) begin errors++; $display("FAIL rst_min: got %h, required %h", stat_min, ones_c); end
    if (stat_max !== '0) begin errors++; $display("FAIL rst_max: got %0d, required 0", stat_max); end
    if (stat_sum !== '0) begin errors++; $display("FAIL rst_sum: got %0d, required 0", stat_sum); end
    if (stat_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %0d, required 0", stat_overflow); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_basic();
    int p0;
    pulse_clear();
    p0 = pulses;
    drive(1'b1, 13'd5, 1'b0, '0, 38'd100);
    step(2);
    drive(1'b0, '0, 1'b1, 13'd5, 38'd350);
    step(5);
    checks += 5;
    if (pulses - p0 !== 1) begin errors++; $display("FAIL basic_pulses: got %0d, required 1", pulses - p0); end
    if (stat_count !== 32'd1) begin errors++; $display("FAIL basic_count: got %0d, required 1", stat_count); end
    if (stat_min !== 38'd250) begin errors++; $display("FAIL basic_min: got %0d, required 250", stat_min); end
    if (stat_max !== 38'd250) begin errors++; $display("FAIL basic_max: got %0d, required 250", stat_max); end
    if (stat_sum !== 56'd250) begin errors++; $display("FAIL basic_sum: got %0d, required 250", stat_sum); end
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] big;
    big = ones_c - 38'd9;
    pulse_clear();
    drive(1'b1, 13'd3, 1'b0, '0, big);
    step(1);
    drive(1'b0, '0, 1'b1, 13'd3, 38'd20);
    step(5);
    checks += 3;
    if (stat_min !== 38'd30) begin errors++; $display("FAIL wrap_min: got %0d, required 30", stat_min); end
    if (stat_max !== 38'd30) begin errors++; $display("FAIL wrap_max: got %0d, required 30", stat_max); end
    if (stat_sum !== 56'd30) begin errors++; $display("FAIL wrap_sum: got %0d, required 30", stat_sum); end
  endtask

  task automatic test_back_to_back();
    int p0;
    pulse_clear();
    for (int i = 0; i < 8; i++) drive(1'b1, ADDR_W'(i), 1'b0, '0, 38'd1000);
    p0 = pulses;
    for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, ADDR_W'(i), CNT_W'(1000 + 10 * (i + 1)));
    step(6);
    checks += 5;
    if (pulses - p0 !== 8) begin errors++; $display("FAIL stream_pulses: got %0d, required 8", pulses - p0); end
    if (stat_count !== 32'd8) begin errors++; $display("FAIL stream_count: got %0d, required 8", stat_count); end
    if (stat_min !== 38'd10) begin errors++; $display("FAIL stream_min: got %0d, required 10", stat_min); end
    if (stat_max !== 38'd80) begin errors++; $display("FAIL stream_max: got %0d, required 80", stat_max); end
    if (stat_sum !== 56'd360) begin errors++; $display("FAIL stream_sum: got %0d, required 360", stat_sum); end
  endtask

  task automatic test_collision();
    pulse_clear();
    drive(1'b1, 13'd9, 1'b0, '0, 38'd50);
    step(1);
    drive(1'b1, 13'd9, 1'b1, 13'd9, 38'd777);
    step(5);
    checks += 3;
    if (stat_count !== 32'd1) begin errors++; $display("FAIL coll_count: got %0d, required 1", stat_count); end
    if (stat_max !== 38'd0) begin errors++; $display("FAIL coll_max: got %0d, required 0", stat_max); end
    if (stat_min !== 38'd0) begin errors++; $display("FAIL coll_min: got %0d, required 0", stat_min); end
  endtask

  task automatic test_clear_vs_update();
    int p0;
    pulse_clear();
    drive(1'b0, '0, 1'b1, 13'd5, 38'd300);
    step(5);
    checks += 1;
    if (stat_count !== 32'd1) begin errors++; $display("FAIL clr_pre_count: got %0d, required 1", stat_count); end
    p0 = pulses;
    drive(1'b0, '0, 1'b1, 13'd5, 38'd400);
    step(2);
    stats_clear = 1'b1;
    step(1);
    stats_clear = 1'b0;
    step(3);
    checks += 5;
    if (pulses - p0 !== 1) begin errors++; $display("FAIL clr_pulse: got %0d, required 1", pulses - p0); end
    if (stat_count !== '0) begin errors++; $display("FAIL clr_count: got %0d, required 0", stat_count); end
    if (stat_min !== ones_c) begin errors++; $display("FAIL clr_min: got %h, required %h", stat_min, ones_c); end
    if (stat_max !== '0) begin errors++; $display("FAIL clr_max: got %0d, required 0", stat_max); end
    if (stat_sum !== '0) begin errors++; $display("FAIL clr_sum: got %0d, required 0", stat_sum); end
  endtask

  task automatic test_reset_mid();
    int p0;
    drive(1'b0, '0, 1'b1, 13'd5, 38'd600);
    step(5);
    p0 = pulses;
    bus.rx_ack_valid = 1'b1;
    bus.rx_seq       = 13'd5;
    latency_counter  = 38'd900;
    step(1);
    bus.rx_ack_valid = 1'b0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(5);
    checks += 6;
    if (pulses - p0 !== 0) begin errors++; $display("FAIL rstmid_pulses: got %0d, required 0", pulses - p0); end
    if (bus.lat_seq !== '0) begin errors++; $display("FAIL rstmid_lat_seq: got %0d, required 0", bus.lat_seq); end
    if (bus.lat_value !== '0) begin errors++; $display("FAIL rstmid_lat_value: got %0d, required 0", bus.lat_value); end
    if (stat_count !== '0) begin errors++; $display("FAIL rstmid_count: got %0d, required 0", stat_count); end
    if (stat_min !== ones_c) begin errors++; $display("FAIL rstmid_min: got %h, required %h", stat_min, ones_c); end
    if (stat_sum !== '0) begin errors++; $display("FAIL rstmid_sum: got %0d, required 0", stat_sum); end
  endtask

`ifdef PCIE_LAT_HIST_EN
  task automatic test_hist();
    logic [HIST_CNT_W-1:0] req;
    pulse_clear();
    drive(1'b1, 13'd20, 1'b0, '0, 38'd1000);
    drive(1'b1, 13'd21, 1'b0, '0, 38'd1000);
    drive(1'b1, 13'd22, 1'b0, '0, 38'd1000);
    drive(1'b0, '0, 1'b1, 13'd20, 38'd1005);
    drive(1'b0, '0, 1'b1, 13'd21, 38'd1020);
    drive(1'b0, '0, 1'b1, 13'd22, 38'd1500);
    step(6);
    for (int b = 0; b < HIST_BINS; b++) begin
      req = (b == 0 || b == 1 || b == 7) ? 32'd1 : 32'd0;
      checks++;
      if (hist_bins[b*HIST_CNT_W +: HIST_CNT_W] !== req) begin
        errors++;
        $display("FAIL hist_bin%0d: got %0d, required %0d", b, hist_bins[b*HIST_CNT_W +: HIST_CNT_W], req);
      end
    end
    pulse_clear();
    checks++;
    if (hist_bins !== '0) begin errors++; $display("FAIL hist_clear: got %h, required 0", hist_bins); end
  endtask
`endif

  initial begin
    ones_c = '1;
    bus.tx_stamp_valid = 1'b0;
    bus.tx_seq         = '0;
    bus.rx_ack_valid   = 1'b0;
    bus.rx_seq         = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_collision();
    test_clear_vs_update();
    test_reset_mid();
`ifdef PCIE_LAT_HIST_EN
    test_hist();
`endif
    step(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending samples, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pcie_latency_stats.md
Name: pcie_latency_stats

Overview:
- Echo-latency measurement block for the PCIe echo test. It sits between TX_ENGINE and RX_ENGINE.
- On each TX it stamps the free-running latency counter into an internal timestamp RAM, indexed by sequence number.
- On each RX it reads the stamp back and computes the round-trip delta modulo 2^CNT_W.
- It streams per-sample results and keeps running min/max/sum/count statistics, clearable at run time from VIO.

Parameters:
- CNT_W, 38, width of the latency counter, stored stamps and latency values.
- ADDR_W, 13, sequence-number width; RAM depth is 2^ADDR_W.
- SUM_W, 56, width of the latency accumulator.
- CNT_SAMPLES_W, 32, width of the sample counter.

Ports:
- clk  in  1  single clock, 250 MHz.
- rst  in  1  asynchronous reset, active-high.
- stats_clear  in  1  synchronous user clear pulse from VIO/RX_ENGINE.
- latency_counter  in  CNT_W  free-running timebase.
- tx_stamp_valid  in  1  TX_ENGINE issued packet tx_seq.
- tx_seq  in  ADDR_W  write address.
- rx_ack_valid  in  1  RX_ENGINE received echo rx_seq.
- rx_seq  in  ADDR_W  read address.
- lat_valid  out  1  one-cycle strobe: sample result ready.
- lat_seq  out  ADDR_W  sequence number of the sample.
- lat_value  out  CNT_W  measured latency in clk cycles.
- stat_count  out  CNT_SAMPLES_W  number of samples since the last clear.
- stat_min  out  CNT_W  minimum latency.
- stat_max  out  CNT_W  maximum latency.
- stat_sum  out  SUM_W  sum of latencies.
- stat_overflow  out  1  sticky flag: stat_sum or stat_count saturated.

Behaviour:
- Reset (rst high, async):
  - lat_valid=0, lat_seq=0, lat_value=0.
  - stat_count=0, stat_max=0, stat_sum=0, stat_overflow=0.
  - stat_min = all-ones.
  - Pipeline valid bits cleared. RAM contents are not cleared.
- Write path:
  - tx_stamp_valid=1 writes latency_counter into mem[tx_seq] at the rising edge.
  - No backpressure; every cycle may write.
- Read pipeline: 3 stages, fixed, one sample per cycle accepted.
  - S0: rx_ack_valid captures rx_seq and latency_counter (the rx timestamp) and issues the RAM read.
  - S1: RAM output register.
  - S2: delta computed; lat_valid asserted.
  - Total latency: rx_ack_valid at cycle N gives lat_valid at cycle N+3.
- Arithmetic:
  - lat_value = (rx_stamp - mem[rx_seq]) mod 2^CNT_W, unsigned.
  - Counter wrap between TX and RX is therefore handled transparently.
- Write/read collision: tx_stamp_valid and rx_ack_valid in the same cycle with tx_seq==rx_seq.
  - The RAM is write-first, so the read returns the new stamp; lat_value is 0.
  - The sample is still counted. This is defined, not an error.
- Statistics: updated in the cycle after lat_valid (visible at N+4).
  - stat_count += 1, saturating at all-ones.
  - stat_sum += lat_value, saturating at all-ones.
  - stat_min = min(stat_min, lat_value); stat_max = max(stat_max, lat_value).
  - Any saturation sets stat_overflow, which is sticky until clear or reset.
- stats_clear:
  - Returns all stat_* outputs to their reset values on the next edge.
  - The pipeline and lat_* outputs are unaffected.
  - If a statistics update coincides with a clear, the clear wins and that sample is dropped from the statistics.
  - The sample is still emitted on lat_*.
- Back-to-back rx_ack_valid every cycle is fully supported; the statistics adder/compare is single-cycle.

Optional Feature:
- Macro: PCIE_LAT_HIST_EN
- With the macro defined:
  - Adds parameter HIST_SHIFT (default 4) and output hist_bins [8*32-1:0].
  - Bin index = min(lat_value >> HIST_SHIFT, 7); bin 7 catches overflow.
  - Each bin is a 32-bit saturating counter, updated in the same cycle as the other stats.
  - Bins are cleared by stats_clear and by rst.
- Without the macro: no histogram logic or port is present; all other behaviour is identical.

Decomposition:
- Package pcie_lat_pkg:
  - Default CNT_W/ADDR_W/SUM_W constants.
  - Pipeline-stage struct typedef (valid, seq, rx_stamp).
  - HIST_BINS=8 constant.
- Sub-module lat_stamp_ram:
  - Inferred simple dual-port RAM with registered output and write-first collision behaviour.
  - Depth 2^ADDR_W, width CNT_W.
  - Replaces the vendor BRAM IP.

Test Plan:
- Basic sample: stamp at counter=100 for seq=5; RX seq=5 at counter=350 -> lat_valid 3 cycles later, lat_value=250, lat_seq=5, stat_count=1, stat_min=stat_max=stat_sum=250.
- Counter wrap: stamp counter=2^38-10; RX at counter=20 -> lat_value=30.
- Streaming: 8 consecutive RX seq 0..7 with latencies 10..80 step 10 -> 8 lat_valid pulses on consecutive cycles, stat_count=8, stat_min=10, stat_max=80, stat_sum=360.
- Collision: tx_stamp and rx_ack in the same cycle, seq=9 -> lat_value=0, stat_count increments.
- Clear vs update: stats_clear coincident with a stats update -> count=0, min=all-ones, max=0, sum=0; lat_valid still pulses.
- Reset mid-pipeline: assert rst one cycle after rx_ack_valid -> no lat_valid ever appears, all outputs at reset values. With PCIE_LAT_HIST_EN and HIST_SHIFT=4, latencies 5/20/500 -> bins 0, 1 and 7 each equal 1.
